// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache between the MEM/WB stage and main memory.
// Latency: hits return rd_data one cycle after the request; misses stall for MEM_LAT+2 (clean) or 2*MEM_LAT+2 (dirty).
// Backpressure: miss holds the pipeline; memory requests are held until mem_gnt. DCACHE_STATS_EN adds access/miss counters.
module dcache_direct_mapped #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [31:0]                            addr,
  input  logic                                   rd_req,
  input  logic                                   wr_req,
  input  logic [31:0]                            wr_data,
  output logic [31:0]                            rd_data,
  output logic                                   miss,
  output logic                                   mem_rd_req,
  output logic                                   mem_wr_req,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
  output logic [(32<<LINE_ADDR_LEN)-1:0]         mem_wr_line,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]         mem_rd_line,
  input  logic                                   mem_gnt
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                            rd_count,
  output logic [31:0]                            wr_count,
  output logic [31:0]                            miss_count
`endif
);

  localparam int SETS    = 1 << SET_ADDR_LEN;
  localparam int LINE_W  = 32 << LINE_ADDR_LEN;
  localparam int ADDR_HI = 2 + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  logic [LINE_W-1:0]         r_data [SETS];
  logic [TAG_ADDR_LEN-1:0]   r_tag  [SETS];
  logic [SETS-1:0]           r_valid;
  logic [SETS-1:0]           r_dirty;
  logic [LINE_W-1:0]         r_fill;
  logic [31:0]               r_rd_data;

  // Set/tag of the line being swapped; latched so a dropped request cannot redirect the swap.
  logic [SET_ADDR_LEN-1:0]   r_miss_set;
  logic [TAG_ADDR_LEN-1:0]   r_miss_tag;

  logic [LINE_ADDR_LEN-1:0]  w_off;
  logic [SET_ADDR_LEN-1:0]   w_set;
  logic [TAG_ADDR_LEN-1:0]   w_tag;
  logic                      w_req;
  logic                      w_hit;
  logic                      w_access;
  logic                      w_start_swap;
  logic                      w_unused_addr;

  assign w_off = addr[2 +: LINE_ADDR_LEN];
  assign w_set = addr[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign w_tag = addr[2+LINE_ADDR_LEN+SET_ADDR_LEN +: TAG_ADDR_LEN];
  assign w_unused_addr = ^{addr[31:ADDR_HI], addr[1:0]};

  assign w_req        = rd_req | wr_req;
  assign w_hit        = r_valid[w_set] && (r_tag[w_set] == w_tag);
  assign w_access     = w_req && (r_state == IDLE) && w_hit;
  assign w_start_swap = w_req && (r_state == IDLE) && !w_hit;

  assign miss        = w_req && !((r_state == IDLE) && w_hit);
  assign rd_data     = r_rd_data;
  assign mem_wr_line = r_data[r_miss_set];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and memory-request decode.
  always_comb begin
    w_next_state = r_state;
    mem_rd_req   = 1'b0;
    mem_wr_req   = 1'b0;
    mem_addr     = {r_miss_tag, r_miss_set};
    case (r_state)
      IDLE: begin
        if (w_start_swap)
          w_next_state = (r_valid[w_set] && r_dirty[w_set]) ? SWAP_OUT : SWAP_IN;
      end
      SWAP_OUT: begin
        mem_wr_req = 1'b1;
        mem_addr   = {r_tag[r_miss_set], r_miss_set};
        if (mem_gnt) w_next_state = SWAP_IN;
      end
      SWAP_IN: begin
        mem_rd_req = 1'b1;
        if (mem_gnt) w_next_state = SWAP_IN_OK;
      end
      SWAP_IN_OK: w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // Line bookkeeping: valid/dirty/tag, swap target latch, fill capture, load data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_dirty    <= '0;
      r_rd_data  <= '0;
      r_miss_set <= '0;
      r_miss_tag <= '0;
      r_fill     <= '0;
    end else begin
      if (w_start_swap) begin
        r_miss_set <= w_set;
        r_miss_tag <= w_tag;
      end
      if (r_state == SWAP_IN && mem_gnt)
        r_fill <= mem_rd_line;
      if (r_state == SWAP_IN_OK) begin
        r_tag[r_miss_set]   <= r_miss_tag;
        r_valid[r_miss_set] <= 1'b1;
        r_dirty[r_miss_set] <= 1'b0;
      end
      if (w_access) begin
        if (rd_req) r_rd_data <= r_data[w_set][{w_off, 5'b0} +: 32];
        if (wr_req) r_dirty[w_set] <= 1'b1;
      end
    end
  end

  // Data array: line fill on SWAP_IN_OK, word store on a write hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == SWAP_IN_OK)
        r_data[r_miss_set] <= r_fill;
      else if (w_access && wr_req)
        r_data[w_set][{w_off, 5'b0} +: 32] <= wr_data;
    end
  end

`ifdef DCACHE_STATS_EN
  // Access and miss counters; a combined read+write counts as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count   <= '0;
      wr_count   <= '0;
      miss_count <= '0;
    end else begin
      if (w_access && rd_req && !wr_req) rd_count <= rd_count + 32'd1;
      if (w_access && wr_req)            wr_count <= wr_count + 32'd1;
      if (w_start_swap)                  miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: directed vector table, hand-written corner sequences, random loads/stores.
// Reference: a flat word memory plus per-set valid/tag/dirty bookkeeping predicting data and stall lengths.
// Main memory model answers each request with mem_gnt in its MEM_LAT-th cycle.
module tb_dcache_direct_mapped;

  localparam int L = 3, S = 2, T = 6;
  localparam int MEM_LAT = 8;
  localparam int NWORDS  = 1 << (L + S + T);
  localparam int LINE_W  = 32 << L;

  logic                clk;
  logic                rst;
  logic [31:0]         addr;
  logic                rd_req, wr_req;
  logic [31:0]         wr_data;
  logic [31:0]         rd_data;
  logic                miss;
  logic                mem_rd_req, mem_wr_req;
  logic [T+S-1:0]      mem_addr;
  logic [LINE_W-1:0]   mem_wr_line;
  logic [LINE_W-1:0]   mem_rd_line;
  logic                mem_gnt;
`ifdef DCACHE_STATS_EN
  logic [31:0]         rd_count, wr_count, miss_count;
`endif

  dcache_direct_mapped #(.LINE_ADDR_LEN(L), .SET_ADDR_LEN(S), .TAG_ADDR_LEN(T)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .rd_data(rd_data), .miss(miss), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt)
`ifdef DCACHE_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .miss_count(miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'h1000_0000 ^ (32'(i) * 32'h0000_9E37);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- main memory model ----------------
  logic [31:0]       mem_words [NWORDS];
  int                mem_cnt;
  logic              force_gnt;
  logic              init_mem;
  logic [T+S-1:0]    last_wr_addr, last_rd_addr;
  logic [LINE_W-1:0] last_wr_line;
  int                rd_gnts;
  logic              both_seen;

  assign mem_gnt = force_gnt | ((mem_rd_req | mem_wr_req) && mem_cnt == MEM_LAT - 1);

  always_comb begin
    mem_rd_line = '0;
    for (int i = 0; i < (1 << L); i++)
      mem_rd_line[i*32 +: 32] = mem_words[int'(mem_addr) * (1 << L) + i];
  end

  always @(posedge clk) begin
    if (rst && init_mem) begin
      for (int i = 0; i < NWORDS; i++) mem_words[i] <= init_word(i);
      rd_gnts   <= 0;
      both_seen <= 1'b0;
    end
    if (mem_rd_req && mem_wr_req) both_seen <= 1'b1;
    if (rst || !(mem_rd_req || mem_wr_req)) begin
      mem_cnt <= 0;
    end else if (mem_gnt) begin
      mem_cnt <= 0;
      if (mem_wr_req) begin
        for (int i = 0; i < (1 << L); i++)
          mem_words[int'(mem_addr) * (1 << L) + i] <= mem_wr_line[i*32 +: 32];
        last_wr_addr <= mem_addr;
        last_wr_line <= mem_wr_line;
      end else begin
        last_rd_addr <= mem_addr;
        rd_gnts      <= rd_gnts + 1;
      end
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [NWORDS];
  bit          m_valid [4];
  bit          m_dirty [4];
  int          m_tag   [4];
  logic [31:0] m_last_rd;
  int          st_rd, st_wr, st_miss;

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin m_valid[s] = 0; m_dirty[s] = 0; m_tag[s] = 0; end
    m_last_rd = 32'h0;
    st_rd = 0; st_wr = 0; st_miss = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                              output int emc, output logic [31:0] erd);
    int wi, s, t;
    wi = int'(a >> 2) % NWORDS;
    s  = (wi / 8) % 4;
    t  = (wi / 32) % 64;
    if (m_valid[s] && m_tag[s] == t) begin
      emc = 0;
    end else begin
      emc = (m_valid[s] && m_dirty[s]) ? 2 * MEM_LAT + 2 : MEM_LAT + 2;
      m_valid[s] = 1; m_tag[s] = t; m_dirty[s] = 0;
      st_miss++;
    end
    erd = r ? ref_mem[wi] : m_last_rd;
    m_last_rd = erd;
    if (w) begin ref_mem[wi] = d; m_dirty[s] = 1; st_wr++; end
    else st_rd++;
  endtask

  // Presents one request and holds it until it completes; entered and left at posedge+1.
  task automatic access(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                        output int mc, output logic [31:0] rdv);
    addr = a; rd_req = r; wr_req = w; wr_data = d; mc = 0;
    #1;
    while (miss && mc < 100) begin
      @(posedge clk); #1;
      mc++;
    end
    @(posedge clk); #1;
    rdv = rd_data;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        r;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_mc;
  } vec_t;

  vec_t vt[6];

  initial begin
    int mc, emc, g0;
    logic [31:0] rdv, erd, a;
    logic r, w;

    vt[0] = '{32'h0000_0010, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF,  MEM_LAT + 2};
    vt[1] = '{32'h0000_0014, 1'b1, 1'b0, 32'h0,         init_word(5),   0};
    vt[2] = '{32'h0000_0018, 1'b1, 1'b0, 32'h0,         init_word(6),   0};
    vt[3] = '{32'h0000_0010, 1'b0, 1'b1, 32'h1234_5678, init_word(6),   0};
    vt[4] = '{32'h0000_0010, 1'b1, 1'b0, 32'h0,         32'h1234_5678,  0};
    vt[5] = '{32'h0000_0410, 1'b1, 1'b0, 32'h0,         init_word(260), 2 * MEM_LAT + 2};

    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
    model_reset();

    rst = 1'b1; init_mem = 1'b1; force_gnt = 1'b0;
    addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; init_mem = 1'b0;

    check("reset_rd_data", rd_data, 32'h0);
    check("reset_miss", {31'b0, miss}, 32'h0);
    check("reset_mem_rd_req", {31'b0, mem_rd_req}, 32'h0);
    check("reset_mem_wr_req", {31'b0, mem_wr_req}, 32'h0);

    // Miss on first load must assert in the same cycle the request appears.
    addr = 32'h10; rd_req = 1'b1; #1;
    check("first_miss_comb", {31'b0, miss}, 32'h1);
    rd_req = 1'b0; #1;

    for (int i = 0; i < 6; i++) begin
      model_access(vt[i].a, vt[i].r, vt[i].w, vt[i].d, emc, erd);
      access(vt[i].a, vt[i].r, vt[i].w, vt[i].d, mc, rdv);
      check($sformatf("vec%0d_miss_cycles", i), 32'(mc), 32'(vt[i].exp_mc));
      check($sformatf("vec%0d_rd_data", i), rdv, vt[i].exp_rd);
    end
    check("evict_wr_addr", 32'(last_wr_addr), 32'h000);
    check("evict_wr_word4", last_wr_line[4*32 +: 32], 32'h1234_5678);
    check("evict_rd_addr", 32'(last_rd_addr), 32'h020);

    // Back-to-back hits in one line: rd_data follows on consecutive cycles, no memory traffic.
    g0 = rd_gnts;
    addr = 32'h414; rd_req = 1'b1; #1;
    check("b2b_miss0", {31'b0, miss}, 32'h0);
    @(posedge clk); #1;
    check("b2b_data0", rd_data, ref_mem[261]);
    addr = 32'h418; #1;
    check("b2b_miss1", {31'b0, miss}, 32'h0);
    @(posedge clk); #1;
    check("b2b_data1", rd_data, ref_mem[262]);
    rd_req = 1'b0;
    m_last_rd = ref_mem[262];
    check("b2b_no_mem", 32'(rd_gnts), 32'(g0));

    // Request dropped mid-swap: the fill still completes, so a later load hits.
    addr = 32'h30; rd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_req = 1'b0; addr = 32'h0;
    repeat (MEM_LAT + 4) @(posedge clk);
    #1;
    m_valid[1] = 1; m_tag[1] = 0; m_dirty[1] = 0;
    model_access(32'h30, 1'b1, 1'b0, 32'h0, emc, erd);
    access(32'h30, 1'b1, 1'b0, 32'h0, mc, rdv);
    check("drop_then_hit_cycles", 32'(mc), 32'(emc));
    check("drop_then_hit_data", rdv, erd);

    // Reset while in SWAP_IN, followed by a stale grant.
    addr = 32'h50; rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("swapin_rd_req", {31'b0, mem_rd_req}, 32'h1);
    rst = 1'b1; rd_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; force_gnt = 1'b1;
    @(posedge clk); #1;
    force_gnt = 1'b0;
    check("post_rst_mem_rd_req", {31'b0, mem_rd_req}, 32'h0);
    check("post_rst_mem_wr_req", {31'b0, mem_wr_req}, 32'h0);
    check("post_rst_rd_data", rd_data, 32'h0);
    model_reset();
    model_access(32'h30, 1'b1, 1'b0, 32'h0, emc, erd);
    access(32'h30, 1'b1, 1'b0, 32'h0, mc, rdv);
    check("post_rst_remiss_cycles", 32'(mc), 32'(MEM_LAT + 2));
    check("post_rst_remiss_data", rdv, erd);

    // Random loads/stores over a small tag range so hits, clean and dirty misses all occur.
    for (int n = 0; n < 150; n++) begin
      int k;
      a = $urandom;
      a[12:7] = 6'($urandom_range(0, 3));
      k = $urandom_range(0, 3);
      r = (k != 1);
      w = (k == 1) || (k == 2);
      wr_data = $urandom;
      model_access(a, r, w, wr_data, emc, erd);
      access(a, r, w, wr_data, mc, rdv);
      check($sformatf("rnd%0d_cycles a=%h", n, a), 32'(mc), 32'(emc));
      check($sformatf("rnd%0d_rd_data a=%h", n, a), rdv, erd);
    end

    check("mem_req_exclusive", {31'b0, both_seen}, 32'h0);

`ifdef DCACHE_STATS_EN
    check("stats_rd_count", rd_count, 32'(st_rd));
    check("stats_wr_count", wr_count, 32'(st_wr));
    check("stats_miss_count", miss_count, 32'(st_miss));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-back, write-allocate data cache: the responder for the MEM/WB stage's cache request interface (addr / rd_req / wr_req / miss).
- Pipeline stage issues word loads/stores. Cache returns registered read data, or holds `miss` high while it swaps lines with main memory over a line-wide handshake.
- Sits between the write-back data stage and the main-memory model.

Parameters:
- LINE_ADDR_LEN, 3, log2(words per line); 8 words/line.
- SET_ADDR_LEN, 2, log2(number of lines); 4 lines.
- TAG_ADDR_LEN, 6, tag width. Addr bits above tag are ignored. Memory space is 2^(TAG+SET+LINE) words.
- MEM_LAT, 8, main-memory model latency in cycles. Used only by the bench memory; documents the expected `mem_gnt` spacing.

Ports:
- clk, input, 1, clock; rising edge.
- rst, input, 1, synchronous active-high reset.
- addr, input, 32, byte address; [1:0] ignored (word access only).
- rd_req, input, 1, load request, level.
- wr_req, input, 1, store request, level.
- wr_data, input, 32, store word.
- rd_data, output, 32, registered load word.
- miss, output, 1, stall; pipeline must hold addr/rd_req/wr_req/wr_data stable while high.
- mem_rd_req, output, 1, line fetch request.
- mem_wr_req, output, 1, line write-back request.
- mem_addr, output, TAG+SET, line address.
- mem_wr_line, output, 32<<LINE_ADDR_LEN, line to write.
- mem_rd_line, input, 32<<LINE_ADDR_LEN, fetched line; valid when `mem_gnt` is high.
- mem_gnt, input, 1, one-cycle completion pulse for the current memory request.

Behaviour:
- Address split: word offset = addr[2+:LINE], set = next SET bits, tag = next TAG bits.
- Per line state: valid, dirty, tag, data array.
- Reset:
  - All valid and dirty bits cleared; FSM goes to IDLE.
  - rd_data = 0, miss = 0, mem_rd_req = mem_wr_req = 0.
  - Reset mid-swap abandons the transfer; a late `mem_gnt` is ignored.
- hit = valid[set] && tag[set] == tag.
- miss (combinational) = (rd_req | wr_req) && !(state == IDLE && hit).
  - Asserts in the same cycle the request is presented.
- Read hit: rd_data <= line word at the next clk edge.
  - One-cycle latency, matching a block-RAM read. rd_data is otherwise unchanged.
- Write hit: word written at clk edge; dirty[set] <= 1.
- rd_req and wr_req both high: treated as a write. rd_data is also updated with the old word.
- FSM:
  - IDLE:
    - Request and !hit and valid and dirty -> SWAP_OUT.
    - Request and !hit otherwise -> SWAP_IN.
    - Otherwise stay.
  - SWAP_OUT:
    - mem_wr_req = 1, mem_addr = {old tag, set}, mem_wr_line = line data.
    - On mem_gnt -> SWAP_IN.
  - SWAP_IN:
    - mem_rd_req = 1, mem_addr = {tag, set}.
    - On mem_gnt: capture mem_rd_line -> SWAP_IN_OK.
  - SWAP_IN_OK:
    - Write captured line, tag; valid = 1, dirty = 0 -> IDLE.
    - Next cycle the request re-evaluates as a hit: miss drops, access completes as a normal hit.
- mem_rd_req and mem_wr_req are never high together. Each is held until its mem_gnt.
- Miss penalty:
  - Clean miss: MEM_LAT + 2 cycles of miss.
  - Dirty miss: 2*MEM_LAT + 2.
- Request dropped while the FSM is busy: the swap still completes; no access is performed.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs rd_count, wr_count, miss_count (32 bits each), synchronous and cleared by rst.
  - rd_count / wr_count increment once per completed access: the cycle the request is high with miss low.
  - miss_count increments on each IDLE -> SWAP_OUT/SWAP_IN transition.
  - Counters wrap at 2^32.
- Undefined: these ports and registers are absent; behaviour otherwise identical.

Test Plan:
- Reset, then load addr 0x0000_0010 -> miss high the same cycle; mem_rd_req with mem_addr 0x000. mem_gnt after 8 cycles with word4 = 0xDEAD_BEEF -> miss low after SWAP_IN_OK; rd_data = 0xDEAD_BEEF the next cycle. Total miss cycles = 10.
- Back-to-back loads 0x14, 0x18 in the same line -> miss never asserts; rd_data updates on consecutive cycles.
- Store 0x1234_5678 to 0x10, then load 0x10 -> hit, rd_data = 0x1234_5678; no memory request.
- Dirty eviction:
  - After the store above, load 0x0000_0410 (same set, different tag) -> mem_wr_req with mem_addr 0x000 and line word4 = 0x1234_5678.
  - After gnt, mem_rd_req with mem_addr 0x020. Miss lasts 18 cycles.
- rst asserted in SWAP_IN, then a stale mem_gnt -> state IDLE, all lines invalid; the reissued load misses again.
- With DCACHE_STATS_EN, run 3 loads and 1 store with 2 misses -> rd_count = 3, wr_count = 1, miss_count = 2.
